// File: rtl/dpsk_tx_scheduler.sv
// Round-robin scheduler sharing one DPSK modulator between two byte requesters.
// Emits preamble + data MSB-first with a bit strobe, then an idle gap.
module dpsk_tx_scheduler #(
  parameter int unsigned BIT_DIV  = 150000,
  parameter logic [7:0]  PREAMBLE = 8'b10101010,
  parameter int unsigned GAP_BITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_bit,
  output logic       tx_bit_stb,
  output logic       enc_ref_clr,
  output logic       tx_active,
  output logic [1:0] grant
);

  localparam int unsigned TMR_W = 18;
  localparam int unsigned GAP_W = 4;
  localparam logic [TMR_W-1:0] TICK_VAL = TMR_W'(BIT_DIV - 1);
  // Unreachable when GAP_BITS is 0 because GAP is then skipped entirely.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_PRE,
    S_DATA,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [TMR_W-1:0]   r_timer;
  logic [2:0]         r_bit_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [7:0]         r_byte;
  logic               r_rr;      // requester favoured when both are valid

  logic       w_tick;
  logic [2:0] w_cnt_dec;
  logic       w_win;

  assign w_tick    = (r_timer == TICK_VAL);
  assign w_cnt_dec = r_bit_cnt - 3'd1;
  assign w_win     = req0_valid ? (req1_valid ? r_rr : 1'b0) : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_byte      <= '0;
      r_rr        <= 1'b0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      tx_bit      <= 1'b0;
      tx_bit_stb  <= 1'b0;
      enc_ref_clr <= 1'b0;
      tx_active   <= 1'b0;
      grant       <= 2'b00;
    end else begin
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      enc_ref_clr <= 1'b0;
      tx_bit_stb  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            r_state     <= S_ACCEPT;
            r_byte      <= w_win ? req1_data : req0_data;
            req0_ready  <= ~w_win;
            req1_ready  <= w_win;
            grant       <= w_win ? 2'b10 : 2'b01;
            enc_ref_clr <= 1'b1;
            r_rr        <= ~w_win;
          end
        end
        S_ACCEPT: begin
          r_state    <= S_PRE;
          r_timer    <= '0;
          r_bit_cnt  <= 3'd7;
          tx_bit     <= PREAMBLE[7];
          tx_bit_stb <= 1'b1;
          tx_active  <= 1'b1;
        end
        S_PRE: begin
          if (w_tick) begin
            r_timer    <= '0;
            tx_bit_stb <= 1'b1;
            if (r_bit_cnt == 3'd0) begin
              r_state   <= S_DATA;
              r_bit_cnt <= 3'd7;
              tx_bit    <= r_byte[7];
            end else begin
              r_bit_cnt <= w_cnt_dec;
              tx_bit    <= PREAMBLE[w_cnt_dec];
            end
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_timer <= '0;
            if (r_bit_cnt == 3'd0) begin
              tx_active <= 1'b0;
              tx_bit    <= 1'b0;
              r_gap_cnt <= '0;
              if (GAP_BITS == 0) begin
                r_state <= S_IDLE;
                grant   <= 2'b00;
              end else begin
                r_state <= S_GAP;
              end
            end else begin
              tx_bit_stb <= 1'b1;
              r_bit_cnt  <= w_cnt_dec;
              tx_bit     <= r_byte[w_cnt_dec];
            end
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_GAP: begin
          if (w_tick) begin
            r_timer <= '0;
            if (r_gap_cnt == GAP_LAST) begin
              r_state <= S_IDLE;
              grant   <= 2'b00;
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpsk_tx_scheduler.sv
// Bench for dpsk_tx_scheduler: frame-level reference model with randomized requesters,
// plus a second instance with GAP_BITS=0 for back-to-back spacing.
module tb_dpsk_tx_scheduler;

  localparam int unsigned BD = 4;
  localparam int unsigned GB = 2;
  localparam logic [7:0]  PRE = 8'b10101010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       tx_bit, tx_bit_stb, enc_ref_clr, tx_active;
  logic [1:0] grant;

  logic       z_req0_valid, z_req1_valid, z_req0_ready, z_req1_ready;
  logic [7:0] z_req0_data, z_req1_data;
  logic       z_tx_bit, z_tx_bit_stb, z_enc_ref_clr, z_tx_active;
  logic [1:0] z_grant;

  dpsk_tx_scheduler #(.BIT_DIV(BD), .PREAMBLE(PRE), .GAP_BITS(GB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_bit(tx_bit), .tx_bit_stb(tx_bit_stb), .enc_ref_clr(enc_ref_clr),
    .tx_active(tx_active), .grant(grant)
  );

  dpsk_tx_scheduler #(.BIT_DIV(BD), .PREAMBLE(PRE), .GAP_BITS(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(z_req0_valid), .req0_data(z_req0_data), .req0_ready(z_req0_ready),
    .req1_valid(z_req1_valid), .req1_data(z_req1_data), .req1_ready(z_req1_ready),
    .tx_bit(z_tx_bit), .tx_bit_stb(z_tx_bit_stb), .enc_ref_clr(z_enc_ref_clr),
    .tx_active(z_tx_active), .grant(z_grant)
  );

  int checks = 0;
  int errors = 0;
  int rr = 0;  // model: requester favoured on contention

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (req0_valid && req1_valid) return rr;
    return req0_valid ? 0 : 1;
  endfunction

  task automatic idle_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_ready0", 8'(req0_ready), 8'd0);
      chk("idle_ready1", 8'(req1_ready), 8'd0);
      chk("idle_grant", 8'(grant), 8'd0);
      chk("idle_active", 8'(tx_active), 8'd0);
    end
  endtask

  // One whole frame: accept, 16 bit periods, gap, back to IDLE.
  task automatic run_frame(input int who, input logic [7:0] byt, input bit cont, input bit glitch);
    logic [15:0] bits;
    logic [7:0]  exp_g;
    int n;
    bit got;
    bit g_on;
    bits  = {PRE, byt};
    exp_g = (who == 0) ? 8'd1 : 8'd2;
    n = 0;
    got = 1'b0;
    g_on = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (req0_ready || req1_ready) got = 1'b1;
    end
    chk("accept_latency", 8'(n), 8'd1);
    if (!got) return;
    chk("ready0", 8'(req0_ready), 8'(who == 0));
    chk("ready1", 8'(req1_ready), 8'(who == 1));
    chk("enc_ref_clr", 8'(enc_ref_clr), 8'd1);
    chk("accept_grant", 8'(grant), exp_g);
    chk("accept_stb", 8'(tx_bit_stb), 8'd0);
    // Winner offers its next byte (or withdraws) while this frame runs.
    if (who == 0) begin
      req0_data  = 8'($urandom);
      req0_valid = cont;
    end else begin
      req1_data  = 8'($urandom);
      req1_valid = cont;
    end
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < int'(BD); c++) begin
        @(negedge clk);
        chk("stb", 8'(tx_bit_stb), 8'(c == 0));
        chk("tx_bit", 8'(tx_bit), 8'(bits[15-k]));
        chk("tx_active", 8'(tx_active), 8'd1);
        chk("grant", 8'(grant), exp_g);
        chk("ready_in_frame", {6'd0, req1_ready, req0_ready}, 8'd0);
        chk("clr_in_frame", 8'(enc_ref_clr), 8'd0);
        if (k == 3 && c == 1 && glitch) begin
          if (who == 0 && !req1_valid) begin req1_valid = 1'b1; g_on = 1'b1; end
          if (who == 1 && !req0_valid) begin req0_valid = 1'b1; g_on = 1'b1; end
        end
        if (k == 3 && c == 2 && g_on) begin
          if (who == 0) req1_valid = 1'b0;
          else          req0_valid = 1'b0;
        end
        if (k == 9 && c == 0 && ($urandom % 2) == 1) begin
          if (who == 0 && !req1_valid) begin req1_valid = 1'b1; req1_data = 8'($urandom); end
          if (who == 1 && !req0_valid) begin req0_valid = 1'b1; req0_data = 8'($urandom); end
        end
      end
    end
    for (int c = 0; c < int'(GB * BD); c++) begin
      @(negedge clk);
      chk("gap_active", 8'(tx_active), 8'd0);
      chk("gap_stb", 8'(tx_bit_stb), 8'd0);
      chk("gap_bit", 8'(tx_bit), 8'd0);
      chk("gap_grant", 8'(grant), exp_g);
      chk("gap_ready", {6'd0, req1_ready, req0_ready}, 8'd0);
    end
    @(negedge clk);
    chk("end_grant", 8'(grant), 8'd0);
    chk("end_stb", 8'(tx_bit_stb), 8'd0);
    chk("end_ready", {6'd0, req1_ready, req0_ready}, 8'd0);
  endtask

  task automatic do_frame(input bit cont, input bit glitch);
    int who;
    logic [7:0] byt;
    who = pick();
    byt = (who == 1) ? req1_data : req0_data;
    rr  = 1 - who;
    run_frame(who, byt, cont, glitch);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int s_cyc[32];
    logic s_bit[32];
    int ns, cyc, rdy0, rdy1, clrs;
    logic [7:0] zb;

    req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
    z_req0_valid = 0; z_req1_valid = 0; z_req0_data = 0; z_req1_data = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {1'b0, req0_ready, req1_ready, tx_bit, tx_bit_stb, enc_ref_clr, grant}, 8'd0);
    chk("reset_active", 8'(tx_active), 8'd0);
    rst_n = 1'b1;
    idle_quiet(5);

    // Contention from reset: req0 first, then alternate.
    rr = 0;
    req0_valid = 1; req0_data = 8'($urandom);
    req1_valid = 1; req1_data = 8'($urandom);
    for (int i = 0; i < 4; i++) do_frame(1'b1, 1'b0);
    req0_valid = 0; req1_valid = 0;
    idle_quiet(3);

    // Single requester with a fixed byte.
    req0_valid = 1; req0_data = 8'hB6;
    do_frame(1'b0, 1'b0);

    // Randomized requester behaviour.
    for (int f = 0; f < 20; f++) begin
      if (!req0_valid && !req1_valid) begin
        idle_quiet(2);
        case ($urandom % 3)
          0: begin req0_valid = 1; req0_data = 8'($urandom); end
          1: begin req1_valid = 1; req1_data = 8'($urandom); end
          default: begin
            req0_valid = 1; req0_data = 8'($urandom);
            req1_valid = 1; req1_data = 8'($urandom);
          end
        endcase
      end
      do_frame(($urandom % 3) != 0, ($urandom % 3) == 0);
    end

    // Asynchronous reset in the middle of the data bits.
    req0_valid = 1; req1_valid = 0; req0_data = 8'($urandom);
    repeat (45) @(negedge clk);
    chk("pre_reset_active", 8'(tx_active), 8'd1);
    req0_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", {1'b0, req0_ready, req1_ready, tx_bit, tx_bit_stb, enc_ref_clr, grant}, 8'd0);
    chk("midframe_reset_active", 8'(tx_active), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rr = 0;
    idle_quiet(4);
    req0_valid = 1; req0_data = 8'($urandom);
    req1_valid = 1; req1_data = 8'($urandom);
    do_frame(1'b0, 1'b0);
    do_frame(1'b0, 1'b0);

    // GAP_BITS=0 instance: continuous demand, fixed byte.
    zb = 8'($urandom);
    z_req0_data = zb;
    z_req0_valid = 1;
    ns = 0; cyc = 0; rdy0 = 0; rdy1 = 0; clrs = 0;
    while (ns < 32 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (z_req0_ready) rdy0++;
      if (z_req1_ready) rdy1++;
      if (z_enc_ref_clr) clrs++;
      if (z_tx_bit_stb) begin
        s_cyc[ns] = cyc;
        s_bit[ns] = z_tx_bit;
        chk("z_active_on_stb", 8'(z_tx_active), 8'd1);
        chk("z_grant_on_stb", 8'(z_grant), 8'd1);
        ns++;
      end
    end
    z_req0_valid = 0;
    chk("z_strobe_count", 8'(ns), 8'd32);
    chk("z_ready0_pulses", 8'(rdy0), 8'd2);
    chk("z_ready1_pulses", 8'(rdy1), 8'd0);
    chk("z_clr_pulses", 8'(clrs), 8'd2);
    for (int i = 0; i < ns; i++) begin
      int b;
      logic e;
      b = i % 16;
      e = (b < 8) ? PRE[7-b] : zb[15-b];
      chk("z_bit", 8'(s_bit[i]), 8'(e));
      if (i > 0) chk("z_spacing", 8'(s_cyc[i] - s_cyc[i-1]), (i == 16) ? 8'd6 : 8'd4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
